// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a carry flop,
// operands consumed LSB first, parallel result presented on a one-cycle done pulse.
module serial_add_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [WIDTH-1:0] sha, sha_nxt;
    logic [WIDTH-1:0] shb, shb_nxt;
    logic [WIDTH-1:0] sum, sum_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             carry, carry_nxt;
    logic             cout_nxt, overflow_nxt, busy_nxt, done_nxt;
    logic             cell_s, cell_c, last, accept;

    // One-bit full adder cell; subtraction arrives as ~b with carry-in 1
    assign cell_s = sha[0] ^ shb[0] ^ carry;
    assign cell_c = (sha[0] & shb[0]) | (sha[0] & carry) | (shb[0] & carry);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = start && ((state == IDLE) || (state == DONE));

    // Next-state and datapath update
    always_comb begin
        state_nxt    = state;
        sha_nxt      = sha;
        shb_nxt      = shb;
        sum_nxt      = sum;
        result_nxt   = result;
        cnt_nxt      = cnt;
        carry_nxt    = carry;
        cout_nxt     = cout;
        overflow_nxt = overflow;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        case (state)
            RUN: begin
                sum_nxt   = {cell_s, sum[WIDTH-1:1]};
                sha_nxt   = {1'b0, sha[WIDTH-1:1]};
                shb_nxt   = {1'b0, shb[WIDTH-1:1]};
                carry_nxt = cell_c;
                if (last) begin
                    cnt_nxt      = '0;
                    result_nxt   = sum_nxt;
                    cout_nxt     = cell_c;
                    overflow_nxt = carry ^ cell_c;
                    state_nxt    = DONE;
                    done_nxt     = 1'b1;
                end else begin
                    cnt_nxt  = cnt + CW'(1);
                    busy_nxt = 1'b1;
                end
            end
            IDLE, DONE: begin
                if (accept) begin
                    sha_nxt   = a;
                    shb_nxt   = op ? ~b : b;
                    carry_nxt = op;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sha      <= '0;
            shb      <= '0;
            sum      <= '0;
            result   <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            sha      <= sha_nxt;
            shb      <= shb_nxt;
            sum      <= sum_nxt;
            result   <= result_nxt;
            cnt      <= cnt_nxt;
            carry    <= carry_nxt;
            cout     <= cout_nxt;
            overflow <= overflow_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: WIDTH=8 and WIDTH=16 instances against an arithmetic
// reference model checked every cycle, plus directed vectors with literal results.
module tb_serial_add_sub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0, op8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        start16 = 1'b0, op16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  res8;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] res16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .cout(cout8), .overflow(ovf8)
    );

    serial_add_sub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(res16), .cout(cout16), .overflow(ovf16)
    );

    // Reference arithmetic from integer values: {overflow, carry, result}
    function automatic logic [17:0] ref_op(logic [15:0] a, logic [15:0] b, logic op, int w);
        int ua, ub, sa, sb, r, u;
        logic c, v;
        ua = int'(a) & ((1 << w) - 1);
        ub = int'(b) & ((1 << w) - 1);
        sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        if (op) begin
            r = sa - sb;
            u = ua - ub;
            c = (ua >= ub);
        end else begin
            r = sa + sb;
            u = ua + ub;
            c = ((ua + ub) >= (1 << w));
        end
        v = (r < -(1 << (w - 1))) || (r > (1 << (w - 1)) - 1);
        return {v, c, 16'(u & ((1 << w) - 1))};
    endfunction

    typedef struct {
        int          left;
        logic        done;
        logic [15:0] res;
        logic        c;
        logic        v;
        logic [17:0] pend;
    } model_t;

    function automatic model_t mzero();
        model_t m;
        m.left = 0; m.done = 1'b0; m.res = '0; m.c = 1'b0; m.v = 1'b0; m.pend = '0;
        return m;
    endfunction

    // One clock of the model: an accepted request completes w edges later
    function automatic model_t mstep(model_t m, logic st, logic [15:0] a, logic [15:0] b,
                                     logic op, int w);
        model_t n = m;
        n.done = 1'b0;
        if (m.left > 0) begin
            n.left = m.left - 1;
            if (n.left == 0) begin
                n.done = 1'b1;
                n.res  = m.pend[15:0];
                n.c    = m.pend[16];
                n.v    = m.pend[17];
            end
        end else if (st) begin
            n.left = w;
            n.pend = ref_op(a, b, op, w);
        end
        return n;
    endfunction

    model_t m8, m16;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m8  = mzero();
            m16 = mzero();
        end else begin
            m8  = mstep(m8,  start8,  {8'h00, a8}, {8'h00, b8}, op8, 8);
            m16 = mstep(m16, start16, a16, b16, op16, 16);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        chk("d8_busy",   32'(busy8),  32'(m8.left > 0));
        chk("d8_done",   32'(done8),  32'(m8.done));
        chk("d8_result", 32'(res8),   32'(m8.res[7:0]));
        chk("d8_cout",   32'(cout8),  32'(m8.c));
        chk("d8_ovf",    32'(ovf8),   32'(m8.v));
        chk("d16_busy",  32'(busy16), 32'(m16.left > 0));
        chk("d16_done",  32'(done16), 32'(m16.done));
        chk("d16_result",32'(res16),  32'(m16.res));
        chk("d16_cout",  32'(cout16), 32'(m16.c));
        chk("d16_ovf",   32'(ovf16),  32'(m16.v));
    end

    // Issue one request; returns at the first negedge after the accepting edge
    task automatic go(input int sel, input logic [15:0] a, input logic [15:0] b, input logic op);
        @(negedge clk);
        if (sel == 0) begin start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; op8 = op; end
        else begin start16 = 1'b1; a16 = a; b16 = b; op16 = op; end
        @(negedge clk);
        if (sel == 0) begin start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 1'($urandom); end
        else begin start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); op16 = 1'($urandom); end
    endtask

    task automatic wait_done(input int sel, input int budget, output int nbusy);
        bit ok = 1'b0;
        nbusy = 0;
        for (int i = 0; i < budget; i++) begin
            if ((sel == 0) ? busy8 : busy16) nbusy++;
            if ((sel == 0) ? done8 : done16) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("done_timeout", 32'(ok), 32'd1);
    endtask

    int nb, gap;

    initial begin
        // Pin the reference model on the hand-computed vectors
        chk("ref_5a_3c", 32'(ref_op(16'h5A, 16'h3C, 1'b0, 8)), 32'h2_0096);
        chk("ref_10_20", 32'(ref_op(16'h10, 16'h20, 1'b1, 8)), 32'h0_00F0);
        chk("ref_80_01", 32'(ref_op(16'h80, 16'h01, 1'b1, 8)), 32'h3_007F);
        chk("ref_ff_01", 32'(ref_op(16'hFF, 16'h01, 1'b0, 8)), 32'h1_0000);

        repeat (2) @(negedge clk);
        chk("rst_result", 32'(res8), 32'h0);
        chk("rst_busy",   32'(busy8), 32'h0);
        rst = 1'b0;

        go(0, 16'h5A, 16'h3C, 1'b0);
        wait_done(0, 40, nb);
        chk("add_busy_cycles", 32'(nb), 32'd8);
        chk("add_result", 32'(res8), 32'h96);
        chk("add_cout",   32'(cout8), 32'h0);
        chk("add_ovf",    32'(ovf8), 32'h1);
        chk("add_busy_in_done", 32'(busy8), 32'h0);
        @(negedge clk);
        chk("add_done_one_cycle", 32'(done8), 32'h0);

        go(0, 16'hFF, 16'h01, 1'b0);
        chk("hold_prev_result", 32'(res8), 32'h96);
        wait_done(0, 40, nb);
        chk("wrap_result", 32'(res8), 32'h00);
        chk("wrap_cout",   32'(cout8), 32'h1);
        chk("wrap_ovf",    32'(ovf8), 32'h0);

        go(0, 16'h10, 16'h20, 1'b1);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h55; b8 = 8'h66; op8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        wait_done(0, 40, nb);
        chk("sub_result", 32'(res8), 32'hF0);
        chk("sub_cout",   32'(cout8), 32'h0);
        chk("sub_ovf",    32'(ovf8), 32'h0);

        go(0, 16'h80, 16'h01, 1'b1);
        wait_done(0, 40, nb);
        chk("subov_result", 32'(res8), 32'h7F);
        chk("subov_cout",   32'(cout8), 32'h1);
        chk("subov_ovf",    32'(ovf8), 32'h1);

        // Start held high: back-to-back operations every WIDTH+1 cycles
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; op8 = 1'b0;
        @(negedge clk);
        wait_done(0, 40, nb);
        gap = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            gap++;
            if (done8) break;
        end
        start8 = 1'b0;
        chk("b2b_period", 32'(gap), 32'd9);
        chk("b2b_result", 32'(res8), 32'h03);

        // Reset in the middle of an operation
        go(0, 16'h33, 16'h44, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy",   32'(busy8), 32'h0);
        chk("abort_result", 32'(res8), 32'h0);
        chk("abort_cout",   32'(cout8), 32'h0);
        chk("abort_ovf",    32'(ovf8), 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) nb++;
        end
        chk("abort_no_done", 32'(nb), 32'd0);
        go(0, 16'h12, 16'h34, 1'b0);
        wait_done(0, 40, nb);
        chk("after_abort_result", 32'(res8), 32'h46);

        chk("w16_ref", 32'(ref_op(16'h7FFF, 16'hFFFF, 1'b1, 16)), 32'h2_8000);
        go(1, 16'h7FFF, 16'hFFFF, 1'b1);
        wait_done(1, 60, nb);
        chk("w16_busy_cycles", 32'(nb), 32'd16);
        chk("w16_result", 32'(res16), 32'h8000);

        for (int i = 0; i < 1000; i++) begin
            go(0, 16'($urandom), 16'($urandom), 1'($urandom));
            wait_done(0, 40, nb);
        end
        for (int i = 0; i < 1000; i++) begin
            go(1, 16'($urandom), 16'($urandom), 1'($urandom));
            wait_done(1, 60, nb);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial N-bit adder/subtractor built around a single one-bit full adder/subtractor cell plus a carry flip-flop. It loads two parallel operands on a start strobe and feeds one bit pair per clock, LSB first, into the cell. It collects the sum bits into a shift register and presents the parallel result with carry-out and signed-overflow flags. It is the sequential stage that drives the one-bit `full_add_sub` cell. It trades WIDTH cycles of latency for one cell of logic.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- op  in  1  0 = add (a+b), 1 = subtract (a−b)
- a  in  WIDTH  operand A, sampled at accepting edge
- b  in  WIDTH  operand B, sampled at accepting edge
- busy  out  1  high while in RUN
- done  out  1  one-cycle completion pulse (high in DONE)
- result  out  WIDTH  sum/difference, updated only at completion
- cout  out  1  final carry out (sub: 1 = no borrow, a ≥ b unsigned)
- overflow  out  1  two's-complement overflow of final result

## Operation
- Reset is asynchronous and active-high. It forces state=IDLE and busy=0, done=0, result=0, cout=0, overflow=0, bit counter=0, carry FF=0, and clears the operand shift registers.
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1:
  - load shA←a and shB←(op ? ~b : b);
  - set carry←op and counter←0;
  - go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, each edge:
  - the cell computes s = shA[0]^shB[0]^carry and c = majority(shA[0], shB[0], carry);
  - shift s into the MSB of the internal sum register; shift shA and shB right by 1;
  - carry←c; counter←counter+1.
- On the edge where counter==WIDTH−1:
  - result←final sum register value, including this edge's s;
  - cout←c;
  - overflow←(carry into the MSB) XOR c, where carry into the MSB is the carry FF value on that same edge;
  - go to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back), going to RUN.
  - Otherwise go to IDLE.
- start in RUN is ignored. The a, b and op inputs are ignored everywhere except at the accepting edge.
- result, cout and overflow hold their last completed values until the next completion or reset. They never show partial sums.
- Arithmetic is modulo 2^WIDTH. Subtraction is a + ~b + 1 through the same cell.
- Reset during RUN aborts the operation: no done pulse, all outputs go to their reset values.

## Timing
- The start edge is E0.
- busy is high after E0 through E_WIDTH, i.e. for WIDTH cycles.
- result, cout, overflow and done become valid after E_WIDTH.
- done is high for the cycle between E_WIDTH and E_WIDTH+1.
- Latency is WIDTH+1 edges from accept to return to IDLE. Throughput is one operation per WIDTH+1 cycles when start is held.
- The counter is ⌈log2 WIDTH⌉ bits and never wraps past WIDTH−1 within an operation.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, add 0x5A+0x3C → after 8 busy cycles: result=0x96, cout=0, overflow=1, done pulse exactly 1 cycle, busy=0 in the done cycle.
- Subtract 0x10−0x20 → result=0xF0, cout=0 (borrow), overflow=0. Subtract 0x80−0x01 → result=0x7F, cout=1, overflow=1.
- Add 0xFF+0x01 → result=0x00, cout=1, overflow=0. result keeps its previous value (e.g. 0x96) throughout RUN.
- Pulse start again mid-RUN with different a/b → ignored; result equals the first operation. Hold start high through DONE → second operation begins with no IDLE cycle and done repeats every 9 cycles.
- Assert rst at cycle 4 of RUN → immediately state=IDLE and result=0, cout=0, overflow=0, busy=0; no done pulse. A subsequent start runs correctly.
- Randomised 1000 operations with WIDTH=8 and WIDTH=16 vs. a reference model (a±b mod 2^WIDTH, carry, signed overflow) → all match.
